// File: rtl/ula_seq.sv
// Sequential ALU with valid/ready on both sides: single-cycle add/sub/logic/shift,
// WIDTH-cycle shift-add multiplier and restoring divider, registered results and flags.
module ula_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             negative,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [2:0]           op_r;
  logic [WIDTH-1:0]     b_r;
  logic [2*WIDTH-1:0]   work_r, work_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [WIDTH-1:0]     result_r, result_hi_r;
  logic                 negative_r, zero_r, carry_r, overflow_r;

  logic                 accept_s, multi_s, last_s;
  logic [WIDTH-1:0]     op_res_s;
  logic                 op_c_s, op_v_s;
  logic [WIDTH:0]       ext_s;
  logic [WIDTH:0]       add_s, trial_s;
  logic [WIDTH-1:0]     diff_s;
  logic [WIDTH-1:0]     fin_res_s, fin_hi_s;
  logic                 fin_c_s, fin_v_s;

  assign accept_s = in_valid && in_ready;
  assign multi_s  = (alu_control == 3'b100) || (alu_control == 3'b101);
  assign last_s   = (cnt_r == CNT_W'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = multi_s ? BUSY : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Single-cycle operations evaluated on the live operands at the accept edge.
  always_comb begin
    op_res_s = {WIDTH{1'b0}};
    op_c_s   = 1'b0;
    op_v_s   = 1'b0;
    ext_s    = {(WIDTH+1){1'b0}};
    case (alu_control)
      3'b000: begin
        ext_s    = {1'b0, a} + {1'b0, b};
        op_res_s = ext_s[WIDTH-1:0];
        op_c_s   = ext_s[WIDTH];
        op_v_s   = (a[MSB] == b[MSB]) && (ext_s[MSB] != a[MSB]);
      end
      3'b001: begin
        op_res_s = a - b;
        op_c_s   = (a >= b);
        op_v_s   = (a[MSB] != b[MSB]) && (op_res_s[MSB] != a[MSB]);
      end
      3'b010: op_res_s = a & b;
      3'b011: op_res_s = a | b;
      3'b110: begin
        // The extra top bit catches the last bit shifted out, so a is never indexed directly.
        if (b == {WIDTH{1'b0}}) begin
          op_res_s = a;
        end else if ({1'b0, b} > (WIDTH+1)'(WIDTH)) begin
          op_res_s = {WIDTH{1'b0}};
        end else begin
          ext_s    = {1'b0, a} << b;
          op_res_s = ext_s[WIDTH-1:0];
          op_c_s   = ext_s[WIDTH];
        end
      end
      3'b111: begin
        if (b == {WIDTH{1'b0}}) begin
          op_res_s = a;
        end else if ({1'b0, b} > (WIDTH+1)'(WIDTH)) begin
          op_res_s = {WIDTH{1'b0}};
        end else begin
          ext_s    = {a, 1'b0} >> b;
          op_res_s = ext_s[WIDTH:1];
          op_c_s   = ext_s[0];
        end
      end
      default: begin
        op_res_s = {WIDTH{1'b0}};
        op_c_s   = 1'b0;
        op_v_s   = 1'b0;
      end
    endcase
  end

  // One multiply or divide iteration on work_r = {upper, lower}.
  always_comb begin
    add_s   = {1'b0, work_r[2*WIDTH-1:WIDTH]} + (work_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    trial_s = {work_r[2*WIDTH-1:WIDTH], work_r[WIDTH-1]};
    diff_s  = trial_s[WIDTH-1:0] - b_r;
    if (op_r == 3'b101) begin
      work_s = {add_s, work_r[WIDTH-1:1]};
    end else if (trial_s >= {1'b0, b_r}) begin
      // b == 0 always takes this branch: quotient fills with ones and a shifts into the remainder.
      work_s = {diff_s, work_r[WIDTH-2:0], 1'b1};
    end else begin
      work_s = {trial_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b0};
    end
    fin_res_s = work_s[WIDTH-1:0];
    fin_hi_s  = work_s[2*WIDTH-1:WIDTH];
    if (op_r == 3'b101) begin
      fin_c_s = |fin_hi_s;
      fin_v_s = |fin_hi_s;
    end else begin
      fin_c_s = 1'b0;
      fin_v_s = (b_r == {WIDTH{1'b0}});
    end
  end

  // Operand capture, iteration state and registered results/flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r        <= 3'b000;
      b_r         <= {WIDTH{1'b0}};
      work_r      <= {(2*WIDTH){1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      result_r    <= {WIDTH{1'b0}};
      result_hi_r <= {WIDTH{1'b0}};
      negative_r  <= 1'b0;
      zero_r      <= 1'b0;
      carry_r     <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (accept_s) begin
      op_r   <= alu_control;
      b_r    <= b;
      work_r <= {{WIDTH{1'b0}}, a};
      cnt_r  <= CNT_W'(WIDTH);
      if (!multi_s) begin
        result_r    <= op_res_s;
        result_hi_r <= {WIDTH{1'b0}};
        negative_r  <= op_res_s[MSB];
        zero_r      <= (op_res_s == {WIDTH{1'b0}});
        carry_r     <= op_c_s;
        overflow_r  <= op_v_s;
      end
    end else if (state_r == BUSY) begin
      work_r <= work_s;
      cnt_r  <= cnt_r - CNT_W'(1);
      if (last_s) begin
        result_r    <= fin_res_s;
        result_hi_r <= fin_hi_s;
        negative_r  <= fin_res_s[MSB];
        zero_r      <= (fin_res_s == {WIDTH{1'b0}});
        carry_r     <= fin_c_s;
        overflow_r  <= fin_v_s;
      end
    end
  end

  assign result    = result_r;
  assign result_hi = result_hi_r;
  assign negative  = negative_r;
  assign zero      = zero_r;
  assign carry     = carry_r;
  assign overflow  = overflow_r;

endmodule
